// File: rtl/sd_spi_init_sequencer.sv
// SD card SPI-mode power-up/initialisation sequencer that drives a bit-level command engine.
// Walks power delay, dummy clocks, CMD0, CMD8, CMD55/ACMD41 polling and CMD58, then reports card type.
module sd_spi_init_sequencer #(
  parameter int POWERUP_CYCLES    = 100000,
  parameter int CMD0_RETRIES      = 8,
  parameter int ACMD41_RETRIES    = 1000,
  parameter int ACMD41_GAP_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        sd_reset,
  output logic        fast_clk_sel,
  output logic        eng_valid,
  input  logic        eng_ready,
  output logic        eng_dummy,
  output logic [5:0]  eng_cmd,
  output logic [31:0] eng_arg,
  output logic [6:0]  eng_crc,
  output logic        eng_resp_long,
  input  logic        eng_done,
  input  logic        eng_timeout,
  input  logic [7:0]  eng_r1,
  input  logic [31:0] eng_data,
  output logic        busy,
  output logic        init_done,
  output logic        init_error,
  output logic [3:0]  error_code,
  output logic        card_v2,
  output logic        card_hcs
);

  localparam int WAIT_MAX = (POWERUP_CYCLES > ACMD41_GAP_CYCLES) ? POWERUP_CYCLES : ACMD41_GAP_CYCLES;
  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam int RW = $clog2(CMD0_RETRIES + 1);
  localparam int PW = $clog2(ACMD41_RETRIES + 1);
  localparam logic [CW-1:0] PU_LAST  = CW'((POWERUP_CYCLES > 0) ? POWERUP_CYCLES - 1 : 0);
  localparam logic [CW-1:0] GAP_LAST = CW'((ACMD41_GAP_CYCLES > 0) ? ACMD41_GAP_CYCLES - 1 : 0);
  localparam logic [RW-1:0] CMD0_MAX = RW'(CMD0_RETRIES);
  localparam logic [PW-1:0] A41_MAX  = PW'(ACMD41_RETRIES);

  typedef enum logic [3:0] {
    S_IDLE, S_POWERUP, S_DUMMY, S_CMD0, S_CMD8, S_CMD55,
    S_ACMD41, S_GAP, S_CMD58, S_DONE, S_ERROR
  } state_t;

  state_t          state, state_d;
  logic            sent, sent_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [RW-1:0]   retry, retry_d, retry_inc;
  logic [PW-1:0]   polls, polls_d, polls_inc;
  logic            v2_d, hcs_d;
  logic [3:0]      err_d;
  logic            resp, resp_ok;

  logic            sd_reset_d, fast_d, valid_d, dummy_d, long_d, busy_d, done_d, error_d;
  logic [5:0]      cmd_d;
  logic [31:0]     arg_d;
  logic [6:0]      crc_d;

  logic            data_unused;
  assign data_unused = ^{eng_data[31], eng_data[29:12]};

  assign retry_inc = retry + 1'b1;
  assign polls_inc = polls + 1'b1;
  // A response only counts once our request has been accepted.
  assign resp      = sent && eng_done;
  assign resp_ok   = resp && !eng_timeout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      sent          <= 1'b0;
      cnt           <= '0;
      retry         <= '0;
      polls         <= '0;
      card_v2       <= 1'b0;
      card_hcs      <= 1'b0;
      error_code    <= 4'd0;
      sd_reset      <= 1'b1;
      fast_clk_sel  <= 1'b0;
      eng_valid     <= 1'b0;
      eng_dummy     <= 1'b0;
      eng_cmd       <= 6'd0;
      eng_arg       <= 32'd0;
      eng_crc       <= 7'd0;
      eng_resp_long <= 1'b0;
      busy          <= 1'b0;
      init_done     <= 1'b0;
      init_error    <= 1'b0;
    end else begin
      state         <= state_d;
      sent          <= sent_d;
      cnt           <= cnt_d;
      retry         <= retry_d;
      polls         <= polls_d;
      card_v2       <= v2_d;
      card_hcs      <= hcs_d;
      error_code    <= err_d;
      sd_reset      <= sd_reset_d;
      fast_clk_sel  <= fast_d;
      eng_valid     <= valid_d;
      eng_dummy     <= dummy_d;
      eng_cmd       <= cmd_d;
      eng_arg       <= arg_d;
      eng_crc       <= crc_d;
      eng_resp_long <= long_d;
      busy          <= busy_d;
      init_done     <= done_d;
      init_error    <= error_d;
    end
  end

  always_comb begin
    state_d = state;
    sent_d  = sent;
    cnt_d   = cnt;
    retry_d = retry;
    polls_d = polls;
    v2_d    = card_v2;
    hcs_d   = card_hcs;
    err_d   = error_code;
    if (eng_valid && eng_ready) sent_d = 1'b1;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_POWERUP;
          sent_d  = 1'b0;
          cnt_d   = '0;
          retry_d = '0;
          polls_d = '0;
          v2_d    = 1'b0;
          hcs_d   = 1'b0;
          err_d   = 4'd0;
        end
      end
      S_POWERUP: begin
        if (cnt >= PU_LAST) begin
          state_d = S_DUMMY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_DUMMY: begin
        if (resp) begin
          state_d = S_CMD0;
          sent_d  = 1'b0;
        end
      end
      S_CMD0: begin
        if (resp) begin
          sent_d = 1'b0;
          if (resp_ok && eng_r1 == 8'h01) begin
            state_d = S_CMD8;
          end else if (retry_inc >= CMD0_MAX) begin
            retry_d = retry_inc;
            state_d = S_ERROR;
            err_d   = 4'd1;
          end else begin
            retry_d = retry_inc;
          end
        end
      end
      S_CMD8: begin
        if (resp) begin
          sent_d = 1'b0;
          if (resp_ok && eng_r1 == 8'h01 && eng_data[11:0] == 12'h1AA) begin
            v2_d    = 1'b1;
            state_d = S_CMD55;
          end else if (resp_ok && eng_r1[2]) begin
            v2_d    = 1'b0;
            state_d = S_CMD55;
          end else begin
            state_d = S_ERROR;
            err_d   = 4'd2;
          end
        end
      end
      S_CMD55: begin
        if (resp) begin
          sent_d = 1'b0;
          if (resp_ok && (eng_r1 == 8'h00 || eng_r1 == 8'h01)) begin
            state_d = S_ACMD41;
          end else begin
            state_d = S_ERROR;
            err_d   = 4'd4;
          end
        end
      end
      S_ACMD41: begin
        if (resp) begin
          sent_d = 1'b0;
          if (resp_ok && eng_r1 == 8'h00) begin
            hcs_d   = 1'b0;
            state_d = card_v2 ? S_CMD58 : S_DONE;
          end else if (resp_ok && eng_r1 == 8'h01) begin
            polls_d = polls_inc;
            if (polls_inc >= A41_MAX) begin
              state_d = S_ERROR;
              err_d   = 4'd3;
            end else begin
              state_d = S_GAP;
              cnt_d   = '0;
            end
          end else begin
            state_d = S_ERROR;
            err_d   = 4'd4;
          end
        end
      end
      S_GAP: begin
        if (cnt >= GAP_LAST) begin
          state_d = S_CMD55;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_CMD58: begin
        if (resp) begin
          sent_d = 1'b0;
          if (resp_ok && eng_r1 == 8'h00) begin
            hcs_d   = eng_data[30];
            state_d = S_DONE;
          end else begin
            state_d = S_ERROR;
            err_d   = 4'd5;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so that the registered copies line up with state.
  always_comb begin
    sd_reset_d = 1'b0;
    fast_d     = 1'b0;
    valid_d    = 1'b0;
    dummy_d    = 1'b0;
    cmd_d      = 6'd0;
    arg_d      = 32'd0;
    crc_d      = 7'd0;
    long_d     = 1'b0;
    busy_d     = 1'b1;
    done_d     = 1'b0;
    error_d    = 1'b0;
    case (state_d)
      S_IDLE: begin
        sd_reset_d = 1'b1;
        busy_d     = 1'b0;
      end
      S_DUMMY: begin
        valid_d = !sent_d;
        dummy_d = 1'b1;
      end
      S_CMD0: begin
        valid_d = !sent_d;
        crc_d   = 7'h4A;
      end
      S_CMD8: begin
        valid_d = !sent_d;
        cmd_d   = 6'd8;
        arg_d   = 32'h0000_01AA;
        crc_d   = 7'h43;
        long_d  = 1'b1;
      end
      S_CMD55: begin
        valid_d = !sent_d;
        cmd_d   = 6'd55;
        crc_d   = 7'h7F;
      end
      S_ACMD41: begin
        valid_d = !sent_d;
        cmd_d   = 6'd41;
        arg_d   = {1'b0, v2_d, 30'd0};
        crc_d   = 7'h7F;
      end
      S_CMD58: begin
        valid_d = !sent_d;
        cmd_d   = 6'd58;
        crc_d   = 7'h7F;
        long_d  = 1'b1;
      end
      S_DONE: begin
        fast_d = 1'b1;
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      S_ERROR: begin
        error_d    = 1'b1;
        busy_d     = 1'b0;
        sd_reset_d = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sd_spi_init_sequencer.sv
// Bench for sd_spi_init_sequencer: a behavioural card/engine model answers requests,
// a table of card scenarios is replayed and the command log is scored against expected sequences.
module tb_sd_spi_init_sequencer;

  localparam int PU   = 5;
  localparam int C0R  = 3;
  localparam int A41R = 4;
  localparam int GAP  = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start_main, start_eng;
  logic        sd_reset, fast_clk_sel, eng_valid, eng_ready, eng_dummy;
  logic [5:0]  eng_cmd;
  logic [31:0] eng_arg;
  logic [6:0]  eng_crc;
  logic        eng_resp_long, eng_done, eng_timeout;
  logic [7:0]  eng_r1;
  logic [31:0] eng_data;
  logic        busy, init_done, init_error;
  logic [3:0]  error_code;
  logic        card_v2, card_hcs;

  assign start = start_main | start_eng;
  always #5 clk = ~clk;

  sd_spi_init_sequencer #(
    .POWERUP_CYCLES(PU), .CMD0_RETRIES(C0R),
    .ACMD41_RETRIES(A41R), .ACMD41_GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .sd_reset(sd_reset), .fast_clk_sel(fast_clk_sel),
    .eng_valid(eng_valid), .eng_ready(eng_ready), .eng_dummy(eng_dummy),
    .eng_cmd(eng_cmd), .eng_arg(eng_arg), .eng_crc(eng_crc), .eng_resp_long(eng_resp_long),
    .eng_done(eng_done), .eng_timeout(eng_timeout), .eng_r1(eng_r1), .eng_data(eng_data),
    .busy(busy), .init_done(init_done), .init_error(init_error),
    .error_code(error_code), .card_v2(card_v2), .card_hcs(card_hcs)
  );

  typedef struct {
    logic             cmd0_to;
    logic [7:0]       cmd8_r1;
    logic [31:0]      cmd8_data;
    int               a41_busy;
    logic [31:0]      ocr;
    logic             stall8;
    logic             exp_done;
    logic [3:0]       exp_err;
    logic             exp_v2;
    logic             exp_hcs;
    logic [31:0]      exp_a41_arg;
    int               exp_n41;
    int               seq_len;
    logic [0:11][5:0] seq;
  } vec_t;

  vec_t tbl[6];
  vec_t sc;

  int n_checks = 0;
  int n_fail   = 0;

  // card / engine model state
  logic        pend, hold_resp, cur_dummy, last41;
  logic [5:0]  cur_cmd;
  logic [31:0] a41_arg;
  int          wait_n, stall_n, cyc, a41_resp_n, done41_cyc;
  int          n_dummy, min_gap;
  logic [5:0]  act_q[$];
  logic [5:0]  exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic to0, input logic [7:0] r1, input logic [31:0] d8,
                              input int a41b, input logic [31:0] ocr, input logic stall,
                              input logic done, input logic [3:0] err, input logic v2,
                              input logic hcs, input logic [31:0] aarg, input int n41,
                              input int len, input logic [0:11][5:0] seq);
    vec_t v;
    v.cmd0_to = to0;  v.cmd8_r1 = r1;   v.cmd8_data = d8; v.a41_busy = a41b;
    v.ocr = ocr;      v.stall8 = stall; v.exp_done = done; v.exp_err = err;
    v.exp_v2 = v2;    v.exp_hcs = hcs;  v.exp_a41_arg = aarg; v.exp_n41 = n41;
    v.seq_len = len;  v.seq = seq;
    return v;
  endfunction

  // Engine model: accepts one request per handshake, answers two cycles later with a done pulse.
  initial begin : engine
    eng_ready = 1'b0; eng_done = 1'b0; eng_timeout = 1'b0; eng_r1 = 8'h00; eng_data = 32'd0;
    pend = 1'b0; wait_n = 0; stall_n = 0; cyc = 0; a41_resp_n = 0; start_eng = 1'b0;
    last41 = 1'b0; done41_cyc = 0; cur_cmd = 6'd0; cur_dummy = 1'b0; a41_arg = 32'hFFFF_FFFF;
    forever begin
      @(negedge clk);
      cyc++;
      eng_done = 1'b0; eng_timeout = 1'b0; start_eng = 1'b0;
      if (!rst_n) begin
        pend = 1'b0; eng_ready = 1'b0; stall_n = 0;
      end else if (eng_ready) begin
        eng_ready = 1'b0;
        chk("valid_drop_after_accept", eng_valid, 1'b0);
        pend = 1'b1; wait_n = 2;
      end else if (pend) begin
        if (!(hold_resp && !cur_dummy && cur_cmd == 6'd55)) begin
          if (wait_n > 0) wait_n--;
          else begin
            pend = 1'b0;
            eng_r1 = 8'hFF; eng_data = 32'd0;
            if (!cur_dummy) begin
              case (cur_cmd)
                6'd0: begin
                  eng_timeout = sc.cmd0_to;
                  eng_r1 = 8'h01;
                end
                6'd8: begin eng_r1 = sc.cmd8_r1; eng_data = sc.cmd8_data; end
                6'd55: eng_r1 = 8'h01;
                6'd41: begin
                  eng_r1 = (a41_resp_n < sc.a41_busy) ? 8'h01 : 8'h00;
                  a41_resp_n++;
                  done41_cyc = cyc; last41 = 1'b1;
                end
                6'd58: begin eng_r1 = 8'h00; eng_data = sc.ocr; end
                default: eng_r1 = 8'hFF;
              endcase
            end
            eng_done = 1'b1;
          end
        end
      end else if (stall_n > 0 && stall_n < 20) begin
        chk("stall_valid", eng_valid, 1'b1);
        chk("stall_cmd", eng_cmd, 6'd8);
        chk("stall_arg", eng_arg, 32'h0000_01AA);
        chk("stall_busy", busy, 1'b1);
        if (stall_n == 5 || stall_n == 12) start_eng = 1'b1;
        stall_n++;
      end else if (eng_valid) begin
        if (sc.stall8 && !eng_dummy && eng_cmd == 6'd8 && stall_n == 0) begin
          stall_n = 1;
        end else begin
          eng_ready = 1'b1;
          cur_cmd = eng_cmd; cur_dummy = eng_dummy;
          if (eng_dummy) begin
            n_dummy++; stall_n = 0; a41_resp_n = 0; last41 = 1'b0; a41_arg = 32'hFFFF_FFFF;
          end else begin
            act_q.push_back(eng_cmd);
            if (eng_cmd == 6'd41 && a41_resp_n == 0) a41_arg = eng_arg;
            if (eng_cmd == 6'd55 && last41) begin
              if (cyc - done41_cyc - 1 < min_gap) min_gap = cyc - done41_cyc - 1;
              last41 = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic chk_reset(input string p);
    chk({p, "_sd_reset"}, sd_reset, 1'b1);
    chk({p, "_fast"}, fast_clk_sel, 1'b0);
    chk({p, "_valid"}, eng_valid, 1'b0);
    chk({p, "_dummy"}, eng_dummy, 1'b0);
    chk({p, "_busy"}, busy, 1'b0);
    chk({p, "_done"}, init_done, 1'b0);
    chk({p, "_error"}, init_error, 1'b0);
    chk({p, "_code"}, error_code, 4'd0);
    chk({p, "_v2"}, card_v2, 1'b0);
    chk({p, "_hcs"}, card_hcs, 1'b0);
  endtask

  task automatic pulse_start();
    @(negedge clk); start_main = 1'b1;
    @(negedge clk); start_main = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int n;
    v = tbl[i];
    sc = v;
    act_q.delete(); exp_q.delete(); n_dummy = 0; min_gap = 1000;
    pulse_start();
    chk($sformatf("v%0d_busy_on_start", i), busy, 1'b1);
    chk($sformatf("v%0d_sd_on", i), sd_reset, 1'b0);
    chk($sformatf("v%0d_clr_done", i), init_done, 1'b0);
    chk($sformatf("v%0d_clr_error", i), init_error, 1'b0);
    chk($sformatf("v%0d_clr_code", i), error_code, 4'd0);
    chk($sformatf("v%0d_clr_v2", i), card_v2, 1'b0);
    chk($sformatf("v%0d_clr_fast", i), fast_clk_sel, 1'b0);
    n = 0;
    while (!(init_done || init_error) && n < 3000) begin
      @(negedge clk); n++;
    end
    chk($sformatf("v%0d_finish_in_budget", i), n < 3000, 1'b1);
    chk($sformatf("v%0d_init_done", i), init_done, v.exp_done);
    chk($sformatf("v%0d_init_error", i), init_error, !v.exp_done);
    chk($sformatf("v%0d_error_code", i), error_code, v.exp_err);
    chk($sformatf("v%0d_card_v2", i), card_v2, v.exp_v2);
    chk($sformatf("v%0d_card_hcs", i), card_hcs, v.exp_hcs);
    chk($sformatf("v%0d_fast_clk", i), fast_clk_sel, v.exp_done);
    chk($sformatf("v%0d_sd_reset", i), sd_reset, !v.exp_done);
    chk($sformatf("v%0d_busy_end", i), busy, 1'b0);
    chk($sformatf("v%0d_dummy_reqs", i), n_dummy, 1);
    if (v.exp_n41 > 0) chk($sformatf("v%0d_acmd41_arg", i), a41_arg, v.exp_a41_arg);
    if (v.exp_n41 > 1) chk($sformatf("v%0d_gap_ge_limit", i), min_gap >= GAP, 1'b1);
    for (int k = 0; k < v.seq_len; k++) exp_q.push_back(v.seq[k]);
    chk($sformatf("v%0d_seq_len", i), act_q.size(), exp_q.size());
    while (exp_q.size() > 0 && act_q.size() > 0)
      chk($sformatf("v%0d_seq_cmd", i), act_q.pop_front(), exp_q.pop_front());
  endtask

  initial begin : main
    int n;
    tbl[0] = mk(1'b0, 8'h01, 32'h0000_01AA, 2, 32'hC0FF_8000, 1'b0,
                1'b1, 4'd0, 1'b1, 1'b1, 32'h4000_0000, 3, 9,
                {6'd0, 6'd8, 6'd55, 6'd41, 6'd55, 6'd41, 6'd55, 6'd41, 6'd58, 6'd0, 6'd0, 6'd0});
    tbl[1] = mk(1'b0, 8'h05, 32'h0000_0000, 1, 32'h0, 1'b1,
                1'b1, 4'd0, 1'b0, 1'b0, 32'h0000_0000, 2, 6,
                {6'd0, 6'd8, 6'd55, 6'd41, 6'd55, 6'd41, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0});
    tbl[2] = mk(1'b1, 8'h01, 32'h0000_01AA, 0, 32'h0, 1'b0,
                1'b0, 4'd1, 1'b0, 1'b0, 32'h0, 0, 3,
                {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0});
    tbl[3] = mk(1'b0, 8'h01, 32'h0000_01AA, 100, 32'h0, 1'b0,
                1'b0, 4'd3, 1'b1, 1'b0, 32'h4000_0000, 4, 10,
                {6'd0, 6'd8, 6'd55, 6'd41, 6'd55, 6'd41, 6'd55, 6'd41, 6'd55, 6'd41, 6'd0, 6'd0});
    tbl[4] = mk(1'b0, 8'h01, 32'h0000_01AB, 0, 32'h0, 1'b0,
                1'b0, 4'd2, 1'b0, 1'b0, 32'h0, 0, 2,
                {6'd0, 6'd8, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0});
    tbl[5] = mk(1'b0, 8'h01, 32'h0000_01AA, 0, 32'h80FF_8000, 1'b0,
                1'b1, 4'd0, 1'b1, 1'b0, 32'h4000_0000, 1, 5,
                {6'd0, 6'd8, 6'd55, 6'd41, 6'd58, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0});
    sc = tbl[0];
    rst_n = 1'b0; start_main = 1'b0; hold_resp = 1'b0; n_dummy = 0; min_gap = 1000;
    repeat (3) @(negedge clk);
    chk_reset("por");
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(i);

    // Reset while waiting on the CMD55 response, then a clean restart.
    sc = tbl[0]; hold_resp = 1'b1;
    act_q.delete(); n_dummy = 0;
    pulse_start();
    n = 0;
    while (!(pend && act_q.size() > 0 && act_q[$] == 6'd55) && n < 500) begin
      @(negedge clk); n++;
    end
    chk("rst_reach_cmd55_wait", n < 500, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset("midrst");
    @(negedge clk);
    rst_n = 1'b1; hold_resp = 1'b0;
    run_vec(0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_spi_init_sequencer.md
Name: sd_spi_init_sequencer

Overview:
Controller that sequences an SD card SPI-mode command engine through power-up and initialization. The sequence is power delay, 80 dummy clocks, CMD0, CMD8, CMD55/ACMD41 polling, then CMD58. On success it reports card version and capacity class and switches the SPI clock from the 400 kHz init rate to the 25 MHz data rate. It sits between the system control logic and the bit-level SD SPI command/response engine, and owns retry, timeout and error policy.

Parameters:
POWERUP_CYCLES, 100000, clk cycles the slot is held powered before dummy clocks (1 ms at 100 MHz).
CMD0_RETRIES, 8, max CMD0 attempts before error.
ACMD41_RETRIES, 1000, max CMD55+ACMD41 pairs before error.
ACMD41_GAP_CYCLES, 100000, idle clk cycles between ACMD41 polls.

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  synchronous reset, active low
start  in  1  one-cycle pulse; begins init from IDLE, DONE or ERROR
sd_reset  out  1  slot power control; 0 = slot powered
fast_clk_sel  out  1  0 = engine uses 400 kHz divider, 1 = 25 MHz
eng_valid  out  1  command request to engine
eng_ready  in  1  engine accepts request
eng_dummy  out  1  1 = request 80 clocks with CS high and MOSI high; cmd fields ignored
eng_cmd  out  6  command index
eng_arg  out  32  command argument
eng_crc  out  7  CRC7, sent as {crc,1'b1}
eng_resp_long  out  1  1 = expect R3/R7 (R1 plus 32 bits)
eng_done  in  1  one-cycle pulse; response or dummy sequence finished
eng_timeout  in  1  valid with eng_done; no R1 start bit within engine limit
eng_r1  in  8  R1 byte, valid with eng_done
eng_data  in  32  trailing R3/R7 bits, valid with eng_done when long
busy  out  1  high from accepted start until DONE/ERROR
init_done  out  1  high in DONE
init_error  out  1  high in ERROR
error_code  out  4  0 none, 1 CMD0, 2 CMD8, 3 ACMD41 timeout, 4 ACMD41 bad R1, 5 CMD58
card_v2  out  1  card answered CMD8 with echo
card_hcs  out  1  CCS bit from OCR (block addressing)

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE. sd_reset=1 (slot off), fast_clk_sel=0, eng_valid=0, eng_dummy=0, busy/init_done/init_error=0, error_code=0, card_v2=0, card_hcs=0, all counters 0. Reset mid-transaction abandons it; eng_valid drops on the next edge.
- Handshake: eng_valid and all eng_* fields are held stable until a cycle with eng_valid&eng_ready. eng_valid falls on the next edge. The FSM then waits for eng_done and ignores eng_ready. eng_done with eng_timeout=1 is a timeout regardless of eng_r1.
- start is ignored while busy. start in DONE/ERROR clears outputs as in reset, except sd_reset, which follows POWERUP.
- States and transitions:
  - IDLE: on start, go to POWERUP. sd_reset=0, busy=1, counter=0.
  - POWERUP: count to POWERUP_CYCLES-1, then go to DUMMY.
  - DUMMY: request with eng_dummy=1. On eng_done, go to CMD0.
  - CMD0: cmd 0, arg 0, crc 7'h4A, short. R1==8'h01 goes to CMD8. Otherwise, including timeout, increment the retry count and reissue CMD0. The CMD0_RETRIES-th failure goes to ERROR with code 1.
  - CMD8: cmd 8, arg 32'h000001AA, crc 7'h43, long.
    - R1==8'h01 and eng_data[11:0]==12'h1AA: card_v2=1, go to ACMD41.
    - R1[2]=1 (illegal command): card_v2=0, go to ACMD41.
    - Anything else, or timeout: go to ERROR with code 2.
  - CMD55: cmd 55, arg 0, crc 7'h7F, short. R1 of 8'h00 or 8'h01 goes to ACMD41_SEND. Anything else goes to ERROR with code 4.
  - ACMD41: alias for CMD55 entry. ACMD41_SEND issues cmd 41, arg {1'b0,card_v2,30'b0}, crc 7'h7F, short.
    - R1==8'h00: go to CMD58 if card_v2, else to DONE with card_hcs=0.
    - R1==8'h01: increment the poll count. Reaching ACMD41_RETRIES goes to ERROR with code 3. Otherwise go to GAP.
    - Other R1 or timeout: go to ERROR with code 4.
  - GAP: wait ACMD41_GAP_CYCLES, then go to CMD55.
  - CMD58: cmd 58, arg 0, crc 7'h7F, long. R1==8'h00 sets card_hcs=eng_data[30] and goes to DONE. Otherwise go to ERROR with code 5.
  - DONE: fast_clk_sel=1, init_done=1, busy=0.
  - ERROR: init_error=1, busy=0, fast_clk_sel=0, sd_reset=1.
- Counters are wide enough for their parameter and do not wrap. Comparisons use >= on the limit.
- All outputs are registered.

Test Plan:
- Model v2 SDHC card: CMD0→01, CMD8→01/000001AA, ACMD41→01 twice then 00, CMD58→00/C0FF8000. Required: sequence 0,8,55,41,55,41,55,41,58; card_v2=1, card_hcs=1, fast_clk_sel=1, init_done=1.
- v1 card: CMD8→R1=05. Required: ACMD41 arg 0, no CMD58, card_v2=0, card_hcs=0, DONE.
- CMD0 always times out with CMD0_RETRIES=3. Required: exactly 3 CMD0 requests, then init_error=1, error_code=1, sd_reset=1.
- ACMD41 always 01 with ACMD41_RETRIES=4 and GAP=10. Required: 4 ACMD41 requests, ≥10 idle cycles between each, error_code=3.
- eng_ready held low 20 cycles on CMD8. Required: eng_cmd/eng_arg stable and eng_valid high throughout; one request accepted; start pulses during busy ignored.
- rst_n low during the CMD55 wait. Required: next cycle all outputs at reset values, eng_valid=0. start afterwards restarts from POWERUP.
